axi_lite_reg_slave: RTL
=======================

Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write control registers to a memory-mapped master.
- Instantiated inside controller IPs behind the block-design interconnect.
- Drives register contents to the controller core.
- Completes the link driven by the AXI VIP master in our IP-level benches (AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST).

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; register index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, implemented registers; legal range 1..2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
s_axi_aclk  in  1  single clock; all logic on its rising edge.
s_axi_aresetn  in  1  reset, asynchronous assert, active-low.
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
s_axi_awprot  in  3  ignored.
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte enables.
s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
s_axi_bresp  out  2  write response.
s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
s_axi_arprot  in  3  ignored.
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
reg_out  out  32*NUM_REGS  register contents; reg i occupies bits [32*i+31:32*i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle reg i is written.

Behaviour:
Reset (aresetn=0, asynchronous):
- All registers 0.
- awready, wready, arready, bvalid, rvalid, reg_wr_pulse = 0.
- bresp, rresp, rdata = 0.
- Readies rise to 1 on the first clock edge after aresetn deasserts.

Write path, states W_IDLE / W_RESP:
- W_IDLE: awready and wready are independent.
  - An AW handshake latches awaddr and drops awready.
  - A W handshake latches wdata/wstrb and drops wready.
  - AW and W may arrive in either order or in the same cycle.
- Commit cycle: the edge on which both AW and W are held (or the second one's handshake occurs).
  - Register updated byte-wise: byte k written only where wstrb[k]=1.
  - reg_wr_pulse[idx]=1 for exactly one cycle after this edge, even if wstrb=0.
  - bvalid=1 with bresp=OKAY (2'b00); go to W_RESP.
- Out-of-range write (idx >= NUM_REGS): no register change, no pulse, bresp=SLVERR (2'b10).
- W_RESP:
  - bvalid and bresp held stable until bready=1.
  - On the B handshake edge: bvalid=0, awready=wready=1, return to W_IDLE.
- Only one write outstanding; awready and wready stay 0 in W_RESP.
- Minimum write turnaround: AW+W handshake, then bvalid visible next cycle.

Read path, states R_IDLE / R_DATA:
- R_IDLE: arready=1. On the AR handshake edge:
  - rdata = register[idx], sampled from pre-edge contents.
  - rresp=OKAY; rvalid=1; arready=0; go to R_DATA.
  - Latency: rvalid one cycle after AR handshake.
- Out-of-range read: rdata=0, rresp=SLVERR.
- R_DATA:
  - rvalid, rdata and rresp held stable until rready=1.
  - On the R handshake edge: rvalid=0, arready=1, return to R_IDLE.
- Only one read outstanding.

Concurrency and corner cases:
- Read and write paths are fully independent and may run in the same cycle.
- Same-cycle AR handshake and write commit to the same register: read returns the old value. A subsequent read returns the new value.
- addr[1:0] ignored; unaligned addresses alias to the containing word.
- VALID signals from the master are never required to depend on this block's READY.
- Reset mid-transaction: all state aborts immediately; no response is issued for the aborted transaction.

Test Plan:
- Sequential writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (wstrb=0xF), then reads of the same addresses -> rdata 0x1..0x4, all bresp/rresp=OKAY, reg_out={4,3,2,1}, one reg_wr_pulse per write.
- Write 0xFFFFFFFF to 0x4, then 0x000000AA with wstrb=0x1 -> read 0x4 returns 0xFFFFFFAA.
- W presented 3 cycles before AW to 0x8 -> bvalid exactly one cycle after AW handshake; reg 2 updated; AW-first ordering gives the same result.
- Write 0xDEAD to 0x10 and read 0x3C (NUM_REGS=4) -> bresp=2'b10, rresp=2'b10, rdata=0, reg_out unchanged, no pulse.
- Hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid, resp and rdata remain stable; awready, wready and arready stay 0; normal completion once ready asserts.
- Assert aresetn=0 while bvalid=1 and rvalid=1 -> all valids and registers 0 immediately; readies return to 1 one cycle after release; the next write/read completes normally.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank responder.
// Independent write and read paths, one transaction outstanding on each.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate;
    wstate_t w_wstate_nxt;
    rstate_t r_rstate;
    rstate_t w_rstate_nxt;

    logic [DW-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic              r_awready;
    logic              r_wready;
    logic              r_aw_held;
    logic              r_w_held;
    logic [IDX_W-1:0]  r_awidx;
    logic [DW-1:0]     r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              r_arready;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [IDX_W-1:0]  w_widx;
    logic [DW-1:0]     w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic              w_wr_ok;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_rd_ok;
    logic [DW-1:0]     w_rd_val;
    logic              w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi_wvalid && r_wready;
    assign w_ar_hs = s_axi_arvalid && r_arready;

    // The second of AW/W to arrive may be used straight off the bus.
    assign w_widx  = r_aw_held ? r_awidx
                               : s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wdata = r_w_held ? r_wdata : s_axi_wdata;
    assign w_wstrb = r_w_held ? r_wstrb : s_axi_wstrb;

    assign w_commit = (r_wstate == W_IDLE)
                   && (r_aw_held || w_aw_hs)
                   && (r_w_held || w_w_hs);

    assign w_wr_ok = {1'b0, w_widx} < (IDX_W+1)'(NUM_REGS);
    assign w_ridx  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_ok = {1'b0, w_ridx} < (IDX_W+1)'(NUM_REGS);

    // Decode write target and read source; out-of-range hits nothing.
    always_comb begin
        w_wr_sel = '0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_widx == IDX_W'(i)) w_wr_sel[i] = 1'b1;
            if (w_ridx == IDX_W'(i)) w_rd_val = r_regs[i];
        end
    end

    // Next-state logic for both channel FSMs.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        unique case (r_wstate)
            W_IDLE: if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        unique case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA: if (s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Write address/data capture, readies and B response.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awidx   <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi_wdata;
                            r_wstrb  <= s_axi_wstrb;
                        end
                        r_awready <= !(r_aw_held || w_aw_hs);
                        r_wready  <= !(r_w_held || w_w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_bvalid <= 1'b0;
            endcase
        end
    end

    // Register bank: byte-enabled update on commit.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_sel[i]) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_wstrb[k]) r_regs[i][8*k +: 8] <= w_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // One-cycle write strobe, fires even for an all-zero wstrb.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= (w_commit && w_wr_ok) ? w_wr_sel : '0;
        end
    end

    // Read address accept and R response; data sampled before any same-edge write.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_ok ? w_rd_val : '0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rvalid <= 1'b0;
            endcase
        end
    end

    // Flatten the bank onto the core-facing bus.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_out[DW*i +: DW] = r_regs[i];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign reg_wr_pulse  = r_wr_pulse;

endmodule
